booth_mul_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one radix-4 Booth multiplier between `N_REQ` requesters. It latches the granted requester's operands and holds them stable for the whole operation. It drives the multiplier's start/ack handshake with interrupt mode enabled, then returns the 32-bit signed product to that requester with a one-cycle done pulse. A watchdog flags a multiplier that stops responding.

---
 rtl/booth_mul_arbiter.sv | 126 ++++++++++++
 tb/tb_booth_mul_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter that shares one radix-4 Booth multiplier between N_REQ requesters,
// sequencing the start/irq/ack handshake and guarding each wait state with a watchdog.
module booth_mul_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WD_CYCLES = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [N_REQ-1:0]     req,
  input  logic [16*N_REQ-1:0]  req_a,
  input  logic [16*N_REQ-1:0]  req_b,
  output logic [N_REQ-1:0]     done,
  output logic [31:0]          result_out,
  output logic                 err,
  output logic                 mul_start,
  output logic                 mul_ack,
  output logic                 mul_irq_enable,
  output logic [15:0]          mul_data_a,
  output logic [15:0]          mul_data_b,
  input  logic                 mul_busy,
  input  logic                 mul_irq,
  input  logic [31:0]          mul_result
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WW = $clog2(WD_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, START, WAIT_BUSY, WAIT_IRQ, ACK, RELEASE
  } state_t;

  state_t          state, state_next;
  logic [IW-1:0]   last, grant, grant_sel;
  logic            grant_valid;
  logic [WW-1:0]   wd_cnt;
  logic            wd_hit, mul_idle;
  logic            start_d, ack_d, err_d, capture, grant_take;
  logic [N_REQ-1:0] done_d;

  assign mul_idle = !mul_busy && !mul_irq;
  assign wd_hit   = (state == WAIT_BUSY || state == WAIT_IRQ || state == RELEASE) &&
                    (wd_cnt == WW'(WD_CYCLES - 1));

  // First set request bit searching upward from last+1, wrapping.
  always_comb begin
    int k;
    logic [IW-1:0] k_idx;
    grant_valid = 1'b0;
    grant_sel   = '0;
    k           = 0;
    k_idx       = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      k     = (int'(last) + i) % N_REQ;
      k_idx = IW'(k);
      if (!grant_valid && req[k_idx]) begin
        grant_valid = 1'b1;
        grant_sel   = k_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (grant_valid && mul_idle) state_next = START;
      START:     state_next = WAIT_BUSY;
      WAIT_BUSY: if (wd_hit) state_next = IDLE;
                 else if (mul_busy) state_next = WAIT_IRQ;
      WAIT_IRQ:  if (wd_hit) state_next = IDLE;
                 else if (mul_irq) state_next = ACK;
      ACK:       state_next = RELEASE;
      RELEASE:   if (wd_hit || mul_idle) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    start_d    = (state_next == START);
    ack_d      = (state_next == ACK);
    capture    = (state == ACK);
    done_d     = capture ? (N_REQ'(1) << grant) : '0;
    err_d      = err | wd_hit;
    grant_take = (state == IDLE) && (state_next == START);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      done           <= '0;
      result_out     <= '0;
      err            <= 1'b0;
      mul_start      <= 1'b0;
      mul_ack        <= 1'b0;
      mul_irq_enable <= 1'b0;
      mul_data_a     <= '0;
      mul_data_b     <= '0;
      last           <= IW'(N_REQ - 1);
      grant          <= '0;
    end else begin
      done           <= done_d;
      err            <= err_d;
      mul_start      <= start_d;
      mul_ack        <= ack_d;
      mul_irq_enable <= 1'b1;
      if (capture) result_out <= mul_result;
      // Operands only change on a grant, so they stay stable until IDLE.
      if (grant_take) begin
        mul_data_a <= req_a[16*grant_sel +: 16];
        mul_data_b <= req_b[16*grant_sel +: 16];
        grant      <= grant_sel;
        last       <= grant_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn)                 wd_cnt <= '0;
    else if (state_next != state) wd_cnt <= '0;
    else if (wd_cnt != '1)        wd_cnt <= wd_cnt + WW'(1);
  end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Scoreboard bench for booth_mul_arbiter with a behavioural multiplier model
// (start edge -> busy, 8 busy cycles -> irq, cleared by ack; optional hang).
module tb_booth_mul_arbiter;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [N-1:0]    req = '0;
  logic [16*N-1:0] req_a = '0, req_b = '0;
  logic [N-1:0]    done;
  logic [31:0]     result_out;
  logic            err, mul_start, mul_ack, mul_irq_enable;
  logic [15:0]     mul_data_a, mul_data_b;
  logic            mul_busy = 1'b0, mul_irq = 1'b0;
  logic [31:0]     mul_result = '0;

  booth_mul_arbiter #(.N_REQ(N), .WD_CYCLES(32)) dut (
    .clk(clk), .resetn(resetn), .req(req), .req_a(req_a), .req_b(req_b),
    .done(done), .result_out(result_out), .err(err),
    .mul_start(mul_start), .mul_ack(mul_ack), .mul_irq_enable(mul_irq_enable),
    .mul_data_a(mul_data_a), .mul_data_b(mul_data_b),
    .mul_busy(mul_busy), .mul_irq(mul_irq), .mul_result(mul_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   errors = 0, checks = 0, n_done = 0, n_start = 0;
  bit   hang = 1'b0;

  function automatic logic [31:0] smul(logic [15:0] a, logic [15:0] b);
    logic signed [31:0] sa, sb2;
    sa  = $signed({{16{a[15]}}, a});
    sb2 = $signed({{16{b[15]}}, b});
    return 32'(sa * sb2);
  endfunction

  // Multiplier model
  logic       start_q = 1'b0;
  logic [3:0] bcnt = '0;
  always @(posedge clk) begin
    start_q <= mul_start;
    if (!resetn) begin
      mul_busy <= 1'b0; mul_irq <= 1'b0; bcnt <= '0; start_q <= 1'b0;
    end else if (mul_ack) begin
      mul_busy <= 1'b0; mul_irq <= 1'b0;
    end else if (mul_start && !start_q && !hang) begin
      mul_busy <= 1'b1; bcnt <= '0;
    end else if (mul_busy && !mul_irq) begin
      bcnt <= bcnt + 4'd1;
      if (bcnt == 4'd7) begin
        mul_irq    <= 1'b1;
        mul_result <= smul(mul_data_a, mul_data_b);
      end
    end
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mul_start) n_start++;
    if (mul_start || mul_ack) check("start_ack_excl", 32'(mul_start & mul_ack), 32'd0);
    if (mul_busy && sb.size() > 0) begin
      check("op_a_hold", 32'(mul_data_a), 32'(sb[0].a));
      check("op_b_hold", 32'(mul_data_b), 32'(sb[0].b));
    end
    if (done != '0) begin
      check("done_onehot", 32'($onehot(done)), 32'd1);
      if (sb.size() == 0) check("unexpected_done", 32'(done), 32'd0);
      else begin
        e = sb.pop_front();
        check("done_idx", 32'(done), 32'(1 << e.idx));
        check("result", result_out, e.p);
      end
      n_done++;
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic set_ops(int i, logic [15:0] a, logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  task automatic push(int i);
    exp_t x;
    x.idx = i;
    x.a   = req_a[16*i +: 16];
    x.b   = req_b[16*i +: 16];
    x.p   = smul(x.a, x.b);
    sb.push_back(x);
  endtask

  task automatic wait_done(int target, int budget, output int c);
    c = 0;
    while (n_done < target && c < budget) begin tick(); c++; end
    if (n_done < target) check("done_timeout", 32'(n_done), 32'(target));
  endtask

  task automatic do_reset();
    resetn = 1'b0; req = '0;
    tick(); tick();
    sb.delete();
    resetn = 1'b1;
    tick();
  endtask

  task automatic do_single(int i, logic [15:0] a, logic [15:0] b);
    int s0, base, c;
    set_ops(i, a, b);
    push(i);
    s0 = n_start; base = n_done;
    req[i] = 1'b1;
    wait_done(base + 1, 30, c);
    req[i] = 1'b0;
    check("latency_le15", 32'(c <= 15), 32'd1);
    repeat (3) tick();
    check("start_pulse_count", 32'(n_start - s0), 32'd1);
  endtask

  initial begin
    int base, c;
    tick(); tick();
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result_out, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_start", 32'(mul_start), 32'd0);
    check("rst_ack", 32'(mul_ack), 32'd0);
    check("rst_data_a", 32'(mul_data_a), 32'd0);
    check("rst_data_b", 32'(mul_data_b), 32'd0);
    check("rst_irq_en", 32'(mul_irq_enable), 32'd0);
    resetn = 1'b1;
    tick();
    check("irq_en_on", 32'(mul_irq_enable), 32'd1);

    do_single(0, 16'd3, 16'hFFFB);
    check("single_value", result_out, 32'hFFFFFFF1);
    do_single(1, 16'h8000, 16'h8000);
    check("min_x_min", result_out, 32'h40000000);
    do_single(1, 16'h7FFF, 16'h8000);
    check("max_x_min", result_out, 32'hC0008000);

    // Simultaneous req0 and req2 straight from reset
    do_reset();
    set_ops(0, 16'h0123, 16'h0456);
    set_ops(2, 16'hF00D, 16'h0042);
    push(0); push(2);
    base = n_done;
    req = 4'b0101;
    wait_done(base + 1, 30, c);
    req[0] = 1'b0;
    wait_done(base + 2, 30, c);
    req[2] = 1'b0;
    repeat (3) tick();

    // Fairness: all four held, two full rounds
    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, 16'(100 * (i + 1)), 16'(-(i + 7)));
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push(i);
    base = n_done;
    req = '1;
    wait_done(base + 8, 8 * 20, c);
    req = '0;
    repeat (3) tick();
    check("fair_sb_empty", 32'(sb.size()), 32'd0);

    // Watchdog: multiplier never goes busy
    do_reset();
    hang = 1'b1;
    base = n_done;
    set_ops(0, 16'd5, 16'd6);
    req[0] = 1'b1;
    c = 0;
    while (!mul_start && c < 5) begin tick(); c++; end
    check("wd_start_seen", 32'(mul_start), 32'd1);
    repeat (25) tick();
    check("wd_err_early", 32'(err), 32'd0);
    c = 0;
    while (!err && c < 20) begin tick(); c++; end
    req[0] = 1'b0;
    check("wd_err_set", 32'(err), 32'd1);
    check("wd_start_low", 32'(mul_start), 32'd0);
    check("wd_ack_low", 32'(mul_ack), 32'd0);
    repeat (3) tick();
    check("wd_no_done", 32'(n_done), 32'(base));
    hang = 1'b0;
    do_single(2, 16'hFFFF, 16'hFFFF);
    check("wd_err_sticky", 32'(err), 32'd1);

    // Reset in WAIT_IRQ
    set_ops(1, 16'd77, 16'd11);
    push(1);
    base = n_done;
    req[1] = 1'b1;
    c = 0;
    while (!mul_busy && c < 10) begin tick(); c++; end
    check("mid_busy_seen", 32'(mul_busy), 32'd1);
    tick(); tick();
    resetn = 1'b0; req = '0;
    tick();
    sb.delete();
    check("mid_done", 32'(done), 32'd0);
    check("mid_result", result_out, 32'd0);
    check("mid_err", 32'(err), 32'd0);
    check("mid_start", 32'(mul_start), 32'd0);
    check("mid_ack", 32'(mul_ack), 32'd0);
    check("mid_data_a", 32'(mul_data_a), 32'd0);
    check("mid_data_b", 32'(mul_data_b), 32'd0);
    check("mid_irq_en", 32'(mul_irq_enable), 32'd0);
    resetn = 1'b1;
    tick();
    check("mid_no_done", 32'(n_done), 32'(base));
    do_single(3, 16'h1234, 16'hFF00);

    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
